dp_mem_param: RTL and testbench

//  Parametrised true-dual-port inferred SRAM; next-generation CPU/video main memory.

---
 rtl/dp_mem_param_if.sv | 43 ++++
 rtl/dp_mem_param.sv | 171 +++++++++++++++++
 tb/tb_dp_mem_param.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dp_mem_param_if.sv
// Request/response bundle for the dual-port memory: two independent
// request ports (A and B), shared ready, and a cross-port collision flag.
interface dp_mem_param_if #(
    parameter int D_WIDTH = 16,
    parameter int A_WIDTH = 13
);
    localparam int M_WIDTH = D_WIDTH / 8;

    logic               ready;
    logic               collision;

    logic               req_a;
    logic [A_WIDTH-1:0] addr_a;
    logic               we_a;
    logic [M_WIDTH-1:0] mask_a;
    logic [D_WIDTH-1:0] wdata_a;
    logic [D_WIDTH-1:0] rdata_a;
    logic               rvalid_a;

    logic               req_b;
    logic [A_WIDTH-1:0] addr_b;
    logic               we_b;
    logic [M_WIDTH-1:0] mask_b;
    logic [D_WIDTH-1:0] wdata_b;
    logic [D_WIDTH-1:0] rdata_b;
    logic               rvalid_b;

    modport master (
        input  ready, collision,
        output req_a, addr_a, we_a, mask_a, wdata_a,
        input  rdata_a, rvalid_a,
        output req_b, addr_b, we_b, mask_b, wdata_b,
        input  rdata_b, rvalid_b
    );

    modport slave (
        output ready, collision,
        input  req_a, addr_a, we_a, mask_a, wdata_a,
        output rdata_a, rvalid_a,
        input  req_b, addr_b, we_b, mask_b, wdata_b,
        output rdata_b, rvalid_b
    );
endinterface

// File: rtl/dp_mem_param.sv
// Parametrised true-dual-port SRAM with byte masks, optional output register,
// read-valid tracking, collision flag and optional post-reset zero-fill.
module dp_mem_param #(
    parameter int    D_WIDTH              = 16,
    parameter int    A_WIDTH              = 13,
    parameter int    OUT_REG              = 0,
    parameter int    CLEAR_ON_RESET       = 0,
    parameter int    INITIALIZE_FROM_FILE = 0,
    parameter string FILE                 = "rom.mem",
    parameter int    FILE_TYPE_BIN        = 0
) (
    input  logic          clk,
    input  logic          rst,
    dp_mem_param_if.slave bus
);
    localparam int M_WIDTH    = D_WIDTH / 8;
    localparam int DEPTH      = 2 ** A_WIDTH;
    localparam int CLR_CYCLES = 2 ** (A_WIDTH - 1);
    localparam logic [A_WIDTH-1:0] CLR_LAST = A_WIDTH'(CLR_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_clearing;
    logic [A_WIDTH-1:0] r_clr_cnt;
    logic               r_ready;

    logic [D_WIDTH-1:0] r_mem [DEPTH];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_RESET;
            r_clr_cnt <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_ready   <= (w_state_next == ST_READY);
            r_clr_cnt <= (r_state == ST_CLEAR) ? r_clr_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clearing   = 1'b0;
        case (r_state)
            ST_RESET: w_state_next = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            ST_CLEAR: begin
                w_clearing = 1'b1;
                if (r_clr_cnt == CLR_LAST)
                    w_state_next = ST_READY;
            end
            ST_READY: w_state_next = ST_READY;
            default:  w_state_next = ST_RESET;
        endcase
    end

    // ------------------------------------------------------------------
    // Request acceptance and write-port muxing (zero-fill borrows both ports)
    // ------------------------------------------------------------------
    logic               w_acc_a, w_acc_b;
    logic               w_rd_a, w_rd_b;
    logic               w_wr_a, w_wr_b;
    logic [A_WIDTH-1:0] w_waddr_a, w_waddr_b;
    logic [M_WIDTH-1:0] w_wmask_a, w_wmask_b;
    logic [D_WIDTH-1:0] w_wdata_a, w_wdata_b;
    logic [M_WIDTH-1:0] w_be_a, w_be_b;

    assign w_acc_a   = bus.req_a & r_ready;
    assign w_acc_b   = bus.req_b & r_ready;
    assign w_rd_a    = w_acc_a & ~bus.we_a;
    assign w_rd_b    = w_acc_b & ~bus.we_b;

    assign w_wr_a    = w_clearing | (w_acc_a & bus.we_a);
    assign w_wr_b    = w_clearing | (w_acc_b & bus.we_b);
    assign w_waddr_a = w_clearing ? A_WIDTH'({r_clr_cnt, 1'b0}) : bus.addr_a;
    assign w_waddr_b = w_clearing ? A_WIDTH'({r_clr_cnt, 1'b1}) : bus.addr_b;
    assign w_wmask_a = w_clearing ? '1 : bus.mask_a;
    assign w_wmask_b = w_clearing ? '1 : bus.mask_b;
    assign w_wdata_a = w_clearing ? '0 : bus.wdata_a;
    assign w_wdata_b = w_clearing ? '0 : bus.wdata_b;

    for (genvar gi = 0; gi < M_WIDTH; gi++) begin : g_be
        assign w_be_a[gi] = w_wr_a & w_wmask_a[gi];
        assign w_be_b[gi] = w_wr_b & w_wmask_b[gi];
    end

    // ------------------------------------------------------------------
    // Storage: port B lanes applied first so port A wins overlapping bytes
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < M_WIDTH; i++) begin
            if (w_be_b[i])
                r_mem[w_waddr_b][8*i +: 8] <= w_wdata_b[8*i +: 8];
        end
        for (int i = 0; i < M_WIDTH; i++) begin
            if (w_be_a[i])
                r_mem[w_waddr_a][8*i +: 8] <= w_wdata_a[8*i +: 8];
        end
    end

    // ------------------------------------------------------------------
    // First read stage; reads sample pre-write contents (read-old-data)
    // ------------------------------------------------------------------
    logic               r_rvalid1_a, r_rvalid1_b;
    logic [D_WIDTH-1:0] r_rdata1_a,  r_rdata1_b;
    logic               r_collision;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid1_a <= 1'b0;
            r_rvalid1_b <= 1'b0;
            r_rdata1_a  <= '0;
            r_rdata1_b  <= '0;
            r_collision <= 1'b0;
        end else begin
            r_rvalid1_a <= w_rd_a;
            r_rvalid1_b <= w_rd_b;
            if (w_rd_a)
                r_rdata1_a <= r_mem[bus.addr_a];
            if (w_rd_b)
                r_rdata1_b <= r_mem[bus.addr_b];
            r_collision <= w_acc_a & w_acc_b & (bus.addr_a == bus.addr_b)
                         & (bus.we_a | bus.we_b);
        end
    end

    assign bus.collision = r_collision;
    assign bus.ready     = r_ready;

    // ------------------------------------------------------------------
    // Optional output register stage
    // ------------------------------------------------------------------
    if (OUT_REG != 0) begin : g_out_reg
        logic               r_rvalid2_a, r_rvalid2_b;
        logic [D_WIDTH-1:0] r_rdata2_a,  r_rdata2_b;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rvalid2_a <= 1'b0;
                r_rvalid2_b <= 1'b0;
                r_rdata2_a  <= '0;
                r_rdata2_b  <= '0;
            end else begin
                r_rvalid2_a <= r_rvalid1_a;
                r_rvalid2_b <= r_rvalid1_b;
                if (r_rvalid1_a)
                    r_rdata2_a <= r_rdata1_a;
                if (r_rvalid1_b)
                    r_rdata2_b <= r_rdata1_b;
            end
        end

        assign bus.rvalid_a = r_rvalid2_a;
        assign bus.rvalid_b = r_rvalid2_b;
        assign bus.rdata_a  = r_rdata2_a;
        assign bus.rdata_b  = r_rdata2_b;
    end else begin : g_no_out_reg
        assign bus.rvalid_a = r_rvalid1_a;
        assign bus.rvalid_b = r_rvalid1_b;
        assign bus.rdata_a  = r_rdata1_a;
        assign bus.rdata_b  = r_rdata1_b;
    end
endmodule

// File: tb/tb_dp_mem_param.sv
// Scoreboard bench for dp_mem_param: three configurations (plain, zero-fill,
// output-registered 32-bit) driven by directed vectors.
module tb_dp_mem_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_m, rst_c, rst_r;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    dp_mem_param_if #(.D_WIDTH(16), .A_WIDTH(13)) if_m ();
    dp_mem_param_if #(.D_WIDTH(16), .A_WIDTH(4))  if_c ();
    dp_mem_param_if #(.D_WIDTH(32), .A_WIDTH(6))  if_r ();

    dp_mem_param #(.D_WIDTH(16), .A_WIDTH(13), .OUT_REG(0), .CLEAR_ON_RESET(0))
        u_main (.clk(clk), .rst(rst_m), .bus(if_m.slave));
    dp_mem_param #(.D_WIDTH(16), .A_WIDTH(4), .OUT_REG(0), .CLEAR_ON_RESET(1))
        u_clr  (.clk(clk), .rst(rst_c), .bus(if_c.slave));
    dp_mem_param #(.D_WIDTH(32), .A_WIDTH(6), .OUT_REG(1), .CLEAR_ON_RESET(0))
        u_reg  (.clk(clk), .rst(rst_r), .bus(if_r.slave));

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    // read ids: 0 main_a, 1 main_b, 2 clr_a, 3 clr_b, 4 reg_a, 5 reg_b
    exp_t q_rd  [6][$];
    int   q_col [3][$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cyc %0d)", name, got, expv, cyc);
        end else
            $display("ok   %s: %h (cyc %0d)", name, got, cyc);
    endtask

    task automatic exp_rd(input int id, input logic [31:0] d, input int lat);
        exp_t e;
        e.data = d;
        e.due  = cyc + lat;
        q_rd[id].push_back(e);
    endtask

    task automatic exp_col(input int id);
        q_col[id].push_back(cyc + 1);
    endtask

    task automatic mon_rd(input int id, input string name, input logic rv, input logic [31:0] rd);
        exp_t e;
        if (rv) begin
            n_cmp++;
            if (q_rd[id].size() == 0) begin
                n_fail++;
                $display("FAIL %s unexpected rvalid: got data %h at cyc %0d, expected no rvalid", name, rd, cyc);
            end else begin
                e = q_rd[id].pop_front();
                if (rd !== e.data || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL %s read: got %h at cyc %0d, expected %h at cyc %0d", name, rd, cyc, e.data, e.due);
                end else
                    $display("ok   %s read: %h at cyc %0d", name, rd, cyc);
            end
        end else if (q_rd[id].size() > 0 && cyc >= q_rd[id][0].due) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s missing rvalid: got none at cyc %0d, expected %h", name, cyc, q_rd[id][0].data);
            void'(q_rd[id].pop_front());
        end
    endtask

    task automatic mon_col(input int id, input string name, input logic coll);
        if (coll) begin
            n_cmp++;
            if (q_col[id].size() > 0 && q_col[id][0] == cyc) begin
                void'(q_col[id].pop_front());
                $display("ok   %s collision at cyc %0d", name, cyc);
            end else begin
                n_fail++;
                $display("FAIL %s collision: got 1 at cyc %0d, expected 0", name, cyc);
            end
        end else if (q_col[id].size() > 0 && cyc >= q_col[id][0]) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s collision: got 0 at cyc %0d, expected 1", name, cyc);
            void'(q_col[id].pop_front());
        end
    endtask

    always @(negedge clk) begin
        mon_rd(0, "main_a", if_m.rvalid_a, 32'(if_m.rdata_a));
        mon_rd(1, "main_b", if_m.rvalid_b, 32'(if_m.rdata_b));
        mon_rd(2, "clr_a",  if_c.rvalid_a, 32'(if_c.rdata_a));
        mon_rd(3, "clr_b",  if_c.rvalid_b, 32'(if_c.rdata_b));
        mon_rd(4, "reg_a",  if_r.rvalid_a, if_r.rdata_a);
        mon_rd(5, "reg_b",  if_r.rvalid_b, if_r.rdata_b);
        mon_col(0, "main", if_m.collision);
        mon_col(1, "clr",  if_c.collision);
        mon_col(2, "reg",  if_r.collision);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy_of(input int id);
        if (id == 0) return if_m.ready;
        if (id == 1) return if_c.ready;
        return if_r.ready;
    endfunction

    task automatic wait_ready(input int id, input string name, input int budget, output int n);
        n = 0;
        while (!rdy_of(id) && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(rdy_of(id)), 32'd1);
    endtask

    task automatic m_op(input logic ra, input logic wa, input logic [12:0] aa, input logic [1:0] ma,
                        input logic [15:0] da, input logic rb, input logic wb, input logic [12:0] ab,
                        input logic [1:0] mb, input logic [15:0] db);
        if_m.req_a = ra; if_m.we_a = wa; if_m.addr_a = aa; if_m.mask_a = ma; if_m.wdata_a = da;
        if_m.req_b = rb; if_m.we_b = wb; if_m.addr_b = ab; if_m.mask_b = mb; if_m.wdata_b = db;
        tick();
        if_m.req_a = 1'b0;
        if_m.req_b = 1'b0;
    endtask

    task automatic c_op(input logic ra, input logic wa, input logic [3:0] aa, input logic [15:0] da,
                        input logic rb, input logic wb, input logic [3:0] ab, input logic [15:0] db);
        if_c.req_a = ra; if_c.we_a = wa; if_c.addr_a = aa; if_c.mask_a = 2'b11; if_c.wdata_a = da;
        if_c.req_b = rb; if_c.we_b = wb; if_c.addr_b = ab; if_c.mask_b = 2'b11; if_c.wdata_b = db;
        tick();
        if_c.req_a = 1'b0;
        if_c.req_b = 1'b0;
    endtask

    task automatic r_op(input logic ra, input logic wa, input logic [5:0] aa, input logic [3:0] ma,
                        input logic [31:0] da, input logic rb, input logic [5:0] ab);
        if_r.req_a = ra; if_r.we_a = wa; if_r.addr_a = aa; if_r.mask_a = ma; if_r.wdata_a = da;
        if_r.req_b = rb; if_r.we_b = 1'b0; if_r.addr_b = ab; if_r.mask_b = '0; if_r.wdata_b = '0;
        tick();
        if_r.req_a = 1'b0;
        if_r.req_b = 1'b0;
    endtask

    task automatic m_wr_a(input logic [12:0] a, input logic [1:0] m, input logic [15:0] d);
        m_op(1'b1, 1'b1, a, m, d, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic m_rd_a(input logic [12:0] a, input logic [15:0] expd);
        exp_rd(0, 32'(expd), 1);
        m_op(1'b1, 1'b0, a, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic m_rd_b(input logic [12:0] a, input logic [15:0] expd);
        exp_rd(1, 32'(expd), 1);
        m_op(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, a, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "timeout");
    end

    logic [31:0] reg_words [4];
    int          n;

    initial begin
        if_m.req_a = 0; if_m.we_a = 0; if_m.addr_a = 0; if_m.mask_a = 0; if_m.wdata_a = 0;
        if_m.req_b = 0; if_m.we_b = 0; if_m.addr_b = 0; if_m.mask_b = 0; if_m.wdata_b = 0;
        if_c.req_a = 0; if_c.we_a = 0; if_c.addr_a = 0; if_c.mask_a = 0; if_c.wdata_a = 0;
        if_c.req_b = 0; if_c.we_b = 0; if_c.addr_b = 0; if_c.mask_b = 0; if_c.wdata_b = 0;
        if_r.req_a = 0; if_r.we_a = 0; if_r.addr_a = 0; if_r.mask_a = 0; if_r.wdata_a = 0;
        if_r.req_b = 0; if_r.we_b = 0; if_r.addr_b = 0; if_r.mask_b = 0; if_r.wdata_b = 0;
        rst_m = 1'b1;
        rst_c = 1'b1;
        rst_r = 1'b1;
        repeat (3) tick();

        // reset state
        check("main_rst_ready",     32'(if_m.ready),     32'd0);
        check("main_rst_rvalid_a",  32'(if_m.rvalid_a),  32'd0);
        check("main_rst_rdata_a",   32'(if_m.rdata_a),   32'd0);
        check("main_rst_collision", 32'(if_m.collision), 32'd0);
        check("clr_rst_ready",      32'(if_c.ready),     32'd0);

        rst_m = 1'b0;
        rst_r = 1'b0;
        wait_ready(0, "main_ready_after_rst", 10, n);
        wait_ready(2, "reg_ready_after_rst", 10, n);

        // byte masks
        m_wr_a(13'h005, 2'b11, 16'h1234);
        m_wr_a(13'h005, 2'b01, 16'hBEEF);
        m_rd_a(13'h005, 16'h12EF);
        m_wr_a(13'h005, 2'b00, 16'hFFFF);
        m_rd_a(13'h005, 16'h12EF);
        m_rd_b(13'h005, 16'h12EF);

        // dual write same word
        exp_col(0);
        m_op(1'b1, 1'b1, 13'h010, 2'b11, 16'hAAAA, 1'b1, 1'b1, 13'h010, 2'b10, 16'h5555);
        m_rd_a(13'h010, 16'hAAAA);
        exp_col(0);
        m_op(1'b1, 1'b1, 13'h010, 2'b10, 16'hAAAA, 1'b1, 1'b1, 13'h010, 2'b01, 16'h5555);
        m_rd_b(13'h010, 16'hAA55);

        // read-old-data on cross-port write
        m_wr_a(13'h020, 2'b11, 16'h1111);
        exp_rd(0, 32'h1111, 1);
        exp_col(0);
        m_op(1'b1, 1'b0, 13'h020, 2'b00, 16'h0000, 1'b1, 1'b1, 13'h020, 2'b11, 16'h2222);
        m_rd_a(13'h020, 16'h2222);

        // both read same word: no collision
        exp_rd(0, 32'h2222, 1);
        exp_rd(1, 32'h2222, 1);
        m_op(1'b1, 1'b0, 13'h020, 2'b00, 16'h0000, 1'b1, 1'b0, 13'h020, 2'b00, 16'h0000);

        // writes to different words on both ports, then parallel reads
        m_op(1'b1, 1'b1, 13'h040, 2'b11, 16'h0A0A, 1'b1, 1'b1, 13'h041, 2'b11, 16'h0B0B);
        exp_rd(0, 32'h0A0A, 1);
        exp_rd(1, 32'h0B0B, 1);
        m_op(1'b1, 1'b0, 13'h040, 2'b00, 16'h0000, 1'b1, 1'b0, 13'h041, 2'b00, 16'h0000);
        repeat (3) tick();
        check("main_rdata_hold",  32'(if_m.rdata_a),  32'h0A0A);
        check("main_rvalid_idle", 32'(if_m.rvalid_a), 32'd0);

        // address extremes
        m_wr_a(13'h1FFF, 2'b11, 16'h7E7E);
        m_wr_a(13'h0000, 2'b11, 16'h0102);
        m_rd_a(13'h1FFF, 16'h7E7E);
        m_rd_b(13'h0000, 16'h0102);

        // reset: outputs clear at once, requests ignored, memory kept
        m_wr_a(13'h030, 2'b11, 16'h1357);
        tick();
        rst_m = 1'b1;
        #1;
        check("main_rstasync_rdata_b", 32'(if_m.rdata_b), 32'd0);
        check("main_rstasync_ready",   32'(if_m.ready),   32'd0);
        m_wr_a(13'h030, 2'b11, 16'h7777);
        m_op(1'b1, 1'b0, 13'h040, 2'b00, 16'h0000, 1'b0, 1'b0, '0, '0, '0);
        rst_m = 1'b0;
        wait_ready(0, "main_ready_after_rst2", 10, n);
        m_rd_a(13'h030, 16'h1357);
        m_rd_a(13'h040, 16'h0A0A);

        // output-registered 32-bit configuration
        reg_words[0] = 32'h11223344;
        reg_words[1] = 32'h55A57788;
        reg_words[2] = 32'h99AABBCC;
        reg_words[3] = 32'hDDEEFF00;
        r_op(1'b1, 1'b1, 6'd0, 4'hF, 32'h11223344, 1'b0, '0);
        r_op(1'b1, 1'b1, 6'd1, 4'hF, 32'h55667788, 1'b0, '0);
        r_op(1'b1, 1'b1, 6'd2, 4'hF, 32'h99AABBCC, 1'b0, '0);
        r_op(1'b1, 1'b1, 6'd3, 4'hF, 32'hDDEEFF00, 1'b0, '0);
        r_op(1'b1, 1'b1, 6'd1, 4'b0100, 32'h00A50000, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            exp_rd(4, reg_words[i], 2);
            r_op(1'b1, 1'b0, 6'(i), '0, '0, 1'b0, '0);
        end
        exp_rd(5, 32'hDDEEFF00, 2);
        r_op(1'b0, 1'b0, '0, '0, '0, 1'b1, 6'd3);
        repeat (2) tick();

        // reset with a read in flight: no rvalid may follow
        r_op(1'b1, 1'b0, 6'd0, '0, '0, 1'b0, '0);
        rst_r = 1'b1;
        #1;
        check("reg_rstasync_rvalid_a", 32'(if_r.rvalid_a), 32'd0);
        check("reg_rstasync_rdata_b",  if_r.rdata_b,       32'd0);
        repeat (3) tick();
        rst_r = 1'b0;
        wait_ready(2, "reg_ready_after_rst2", 10, n);
        exp_rd(4, 32'h99AABBCC, 2);
        r_op(1'b1, 1'b0, 6'd2, '0, '0, 1'b0, '0);

        // zero-fill after reset
        rst_c = 1'b0;
        n = 0;
        while (!if_c.ready && n < 20) begin
            tick();
            n++;
        end
        $display("info clr ready after %0d cycles", n);
        check("clr_ready_delay_8to9", 32'(n >= 8 && n <= 9), 32'd1);
        for (int i = 0; i < 8; i++) begin
            exp_rd(2, 32'd0, 1);
            exp_rd(3, 32'd0, 1);
            c_op(1'b1, 1'b0, 4'(i), '0, 1'b1, 1'b0, 4'(i + 8), '0);
        end
        c_op(1'b1, 1'b1, 4'd3, 16'h4242, 1'b1, 1'b1, 4'd12, 16'h4343);
        exp_rd(2, 32'h4242, 1);
        exp_rd(3, 32'h4343, 1);
        c_op(1'b1, 1'b0, 4'd3, '0, 1'b1, 1'b0, 4'd12, '0);
        tick();
        rst_c = 1'b1;
        #1;
        check("clr_rstasync_rdata_a", 32'(if_c.rdata_a), 32'd0);
        tick();
        rst_c = 1'b0;
        repeat (3) tick();
        check("clr_ready_during_clear", 32'(if_c.ready), 32'd0);
        rst_c = 1'b1;
        repeat (2) tick();
        rst_c = 1'b0;
        wait_ready(1, "clr_ready_after_rst2", 20, n);
        exp_rd(2, 32'd0, 1);
        exp_rd(3, 32'd0, 1);
        c_op(1'b1, 1'b0, 4'd3, '0, 1'b1, 1'b0, 4'd12, '0);

        repeat (6) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
